// File: rtl/l3_arbiter_if.sv
// Core-side and RAM-side signal bundle for the shared L3 arbiter.
// The arbiter connects through the slave modport; the cores plus the RAM
// model sit on the master side.
interface l3_arbiter_if #(
  parameter int NCORE = 4,
  parameter int DW    = 8,
  parameter int AW    = 8
);
  // core request side (core i in element [i])
  logic [NCORE-1:0]          req;
  logic [NCORE-1:0]          we;
  logic [NCORE-1:0][AW-1:0]  addr;
  logic [NCORE-1:0][DW-1:0]  wdata;
  logic [NCORE-1:0]          ack;
  logic [NCORE-1:0]          gnt;
  logic [DW-1:0]             rdata;
  logic                      busy;
  // RAM side
  logic                      mem_en;
  logic                      mem_we;
  logic [AW-1:0]             mem_addr;
  logic [DW-1:0]             mem_wdata;
  logic [DW-1:0]             mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output ack, gnt, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  ack, gnt, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/l3_arbiter.sv
// Round-robin arbiter/sequencer for the single-port shared L3 RAM.
// One transaction at a time: IDLE picks a core, ISSUE strobes the RAM,
// WAIT counts out the RAM latency, DONE pulses ack to the owner.
// Every output comes straight from a flop.
module l3_arbiter #(
  parameter int NCORE   = 4,
  parameter int DW      = 8,
  parameter int AW      = 8,
  parameter int MEM_LAT = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  l3_arbiter_if.slave  io_bus
);

  localparam int PW = $clog2(NCORE);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [PW-1:0]         r_ptr, w_ptr_nxt;
  logic [PW-1:0]         r_owner, w_owner_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [NCORE-1:0]      r_ack, w_ack_nxt;
  logic [NCORE-1:0]      r_gnt, w_gnt_nxt;
  logic [DW-1:0]         r_rdata, w_rdata_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_mem_en, w_mem_en_nxt;
  logic                  r_mem_we, w_mem_we_nxt;
  logic [AW-1:0]         r_mem_addr, w_mem_addr_nxt;
  logic [DW-1:0]         r_mem_wdata, w_mem_wdata_nxt;

  logic                  w_found;
  logic [PW-1:0]         w_win;

  // Rotating-priority search: first set req bit starting at ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NCORE; i++) begin
      int idx;
      idx = int'(r_ptr) + i;
      if (idx >= NCORE) idx = idx - NCORE;
      if (!w_found && io_bus.req[idx]) begin
        w_found = 1'b1;
        w_win   = PW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus next values of every registered output.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_owner_nxt     = r_owner;
    w_cnt_nxt       = r_cnt;
    w_ack_nxt       = '0;
    w_gnt_nxt       = r_gnt;
    w_rdata_nxt     = r_rdata;
    w_mem_en_nxt    = 1'b0;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          // capture the winner's command; mem_en is raised now so it is
          // visible from its flop during the ISSUE cycle
          w_owner_nxt     = w_win;
          w_mem_we_nxt    = io_bus.we[w_win];
          w_mem_addr_nxt  = io_bus.addr[w_win];
          w_mem_wdata_nxt = io_bus.wdata[w_win];
          w_gnt_nxt       = NCORE'(1) << w_win;
          w_mem_en_nxt    = 1'b1;
          w_state_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = CW'(MEM_LAT - 1);
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          // RAM data is valid this cycle; writes keep the old rdata
          if (!r_mem_we) w_rdata_nxt = io_bus.mem_rdata;
          w_ack_nxt   = NCORE'(1) << r_owner;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_DONE: begin
        w_ptr_nxt   = (r_owner == PW'(NCORE - 1)) ? '0 : r_owner + 1'b1;
        w_gnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // Datapath and output registers; async reset aborts any transaction.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_ptr       <= '0;
      r_owner     <= '0;
      r_cnt       <= '0;
      r_ack       <= '0;
      r_gnt       <= '0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ack       <= w_ack_nxt;
      r_gnt       <= w_gnt_nxt;
      r_rdata     <= w_rdata_nxt;
      r_busy      <= w_busy_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  assign io_bus.ack       = r_ack;
  assign io_bus.gnt       = r_gnt;
  assign io_bus.rdata     = r_rdata;
  assign io_bus.busy      = r_busy;
  assign io_bus.mem_en    = r_mem_en;
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_l3_arbiter.sv
// Directed bench for l3_arbiter. Three arbiters (MEM_LAT 2, 1, 4) share the
// same core-side stimulus; each has its own RAM model. Instance 0 (MEM_LAT=2)
// carries most checks; instances 1 and 2 cover the latency variants.
module tb_l3_arbiter;
  localparam int NCORE = 4;
  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int NI    = 3;
  localparam int LATS [NI] = '{2, 1, 4};

  logic CLK;
  logic RESET;
  logic [NCORE-1:0]         req;
  logic [NCORE-1:0]         we;
  logic [NCORE-1:0][AW-1:0] addr;
  logic [NCORE-1:0][DW-1:0] wdata;

  logic [NCORE-1:0] ack_o    [NI];
  logic [NCORE-1:0] gnt_o    [NI];
  logic [DW-1:0]    rdata_o  [NI];
  logic             busy_o   [NI];
  logic             men_o    [NI];
  logic             mwe_o    [NI];
  logic [AW-1:0]    maddr_o  [NI];
  logic [DW-1:0]    mwdata_o [NI];

  int checks = 0;
  int errors = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int L = LATS[k];
    l3_arbiter_if #(.NCORE(NCORE), .DW(DW), .AW(AW)) ifc ();
    logic [DW-1:0] ram [256];
    logic [DW-1:0] dpipe [L];
    logic [L-1:0]  vpipe;
    bit            seeded;

    assign ifc.req   = req;
    assign ifc.we    = we;
    assign ifc.addr  = addr;
    assign ifc.wdata = wdata;
    assign ifc.mem_rdata = vpipe[L-1] ? dpipe[L-1] : 8'hEE;

    l3_arbiter #(.NCORE(NCORE), .DW(DW), .AW(AW), .MEM_LAT(L)) dut (
      .CLK    (CLK),
      .RESET  (RESET),
      .io_bus (ifc)
    );

    // RAM model: content a^0x5A except [0x15]=0xA7; read data appears
    // L cycles after the mem_en cycle and reads 0xEE at any other time.
    always @(posedge CLK) begin
      if (!seeded) begin
        for (int a = 0; a < 256; a++) ram[a] <= 8'(a) ^ 8'h5A;
        ram[8'h15] <= 8'hA7;
        seeded <= 1'b1;
      end else if (ifc.mem_en && ifc.mem_we) begin
        ram[ifc.mem_addr] <= ifc.mem_wdata;
      end
      dpipe[0] <= ram[ifc.mem_addr];
      vpipe[0] <= ifc.mem_en;
      for (int i = 1; i < L; i++) begin
        dpipe[i] <= dpipe[i-1];
        vpipe[i] <= vpipe[i-1];
      end
    end

    assign ack_o[k]    = ifc.ack;
    assign gnt_o[k]    = ifc.gnt;
    assign rdata_o[k]  = ifc.rdata;
    assign busy_o[k]   = ifc.busy;
    assign men_o[k]    = ifc.mem_en;
    assign mwe_o[k]    = ifc.mem_we;
    assign maddr_o[k]  = ifc.mem_addr;
    assign mwdata_o[k] = ifc.mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCORE-1:0] e_oh;
    int core;
    RESET = 1'b0;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;

    // reset state
    tick(2);
    for (int k = 0; k < NI; k++) begin
      chk("rst_ack",   32'(ack_o[k]),   32'h0);
      chk("rst_gnt",   32'(gnt_o[k]),   32'h0);
      chk("rst_busy",  32'(busy_o[k]),  32'h0);
      chk("rst_men",   32'(men_o[k]),   32'h0);
    end
    chk("rst_rdata", 32'(rdata_o[0]),  32'h0);
    chk("rst_mwe",   32'(mwe_o[0]),    32'h0);
    chk("rst_maddr", 32'(maddr_o[0]),  32'h0);
    chk("rst_mwd",   32'(mwdata_o[0]), 32'h0);
    RESET = 1'b1;
    tick(1);

    // single read core 2 addr 0x15, req dropped right after capture
    req = 4'b0100; we = 4'b0000; addr[2] = 8'h15;
    tick(1);                                           // cycle 1
    req = '0;
    chk("rd_men",   32'(men_o[0]),   32'h1);
    chk("rd_maddr", 32'(maddr_o[0]), 32'h15);
    chk("rd_mwe",   32'(mwe_o[0]),   32'h0);
    chk("rd_gnt",   32'(gnt_o[0]),   32'h4);
    chk("rd_busy",  32'(busy_o[0]),  32'h1);
    chk("l1_men",   32'(men_o[1]),   32'h1);
    chk("l4_men",   32'(men_o[2]),   32'h1);
    tick(1);                                           // cycle 2
    for (int k = 0; k < NI; k++) chk("men_1wide", 32'(men_o[k]), 32'h0);
    tick(1);                                           // cycle 3
    chk("l1_ack",   32'(ack_o[1]),   32'h4);
    chk("l1_rdata", 32'(rdata_o[1]), 32'hA7);
    chk("rd_noack3", 32'(ack_o[0]),  32'h0);
    tick(1);                                           // cycle 4
    chk("rd_ack",   32'(ack_o[0]),   32'h4);
    chk("rd_rdata", 32'(rdata_o[0]), 32'hA7);
    chk("l1_ack1c", 32'(ack_o[1]),   32'h0);
    chk("l4_noack", 32'(ack_o[2]),   32'h0);
    tick(1);                                           // cycle 5
    chk("rd_ack1c", 32'(ack_o[0]),   32'h0);
    chk("rd_gnt0",  32'(gnt_o[0]),   32'h0);
    chk("rd_busy0", 32'(busy_o[0]),  32'h0);
    chk("rd_hold",  32'(rdata_o[0]), 32'hA7);
    tick(1);                                           // cycle 6
    chk("l4_ack",   32'(ack_o[2]),   32'h4);
    chk("l4_rdata", 32'(rdata_o[2]), 32'hA7);
    tick(2);

    // write core 0, then read back through core 1
    req = 4'b0001; we = 4'b0001; addr[0] = 8'h03; wdata[0] = 8'h5C;
    tick(1);                                           // cycle 1
    req = '0; we = '0;
    chk("wr_men",   32'(men_o[0]),    32'h1);
    chk("wr_mwe",   32'(mwe_o[0]),    32'h1);
    chk("wr_maddr", 32'(maddr_o[0]),  32'h03);
    chk("wr_mwd",   32'(mwdata_o[0]), 32'h5C);
    tick(1);                                           // cycle 2
    chk("wr_men1c", 32'(men_o[0]),    32'h0);
    tick(2);                                           // cycle 4
    chk("wr_ack",   32'(ack_o[0]),    32'h1);
    chk("wr_rdkeep", 32'(rdata_o[0]), 32'hA7);
    tick(1);                                           // cycle 5 (IDLE)
    req = 4'b0010; addr[1] = 8'h03;
    tick(1);
    req = '0;
    chk("rb_gnt",   32'(gnt_o[0]),    32'h2);
    tick(3);
    chk("rb_ack",   32'(ack_o[0]),    32'h2);
    chk("rb_rdata", 32'(rdata_o[0]),  32'h5C);
    tick(4);

    // all four cores held from reset: order 0,1,2,3,0, acks 5 cycles apart
    RESET = 1'b0;
    req = 4'b1111; we = '0;
    for (int i = 0; i < NCORE; i++) addr[i] = 8'h10 + 8'(i);
    tick(2);
    RESET = 1'b1;                                      // cycle 0
    for (int c = 1; c < 25; c++) begin
      tick(1);
      core = (c / 5) % NCORE;
      e_oh = (c % 5 == 0) ? 4'b0000 : (4'b0001 << core);
      chk("rr_gnt", 32'(gnt_o[0]), 32'(e_oh));
      e_oh = (c % 5 == 4) ? (4'b0001 << core) : 4'b0000;
      chk("rr_ack", 32'(ack_o[0]), 32'(e_oh));
      if (c % 5 == 4)
        chk("rr_rdata", 32'(rdata_o[0]), 32'((8'h10 + 8'(core)) ^ 8'h5A));
    end
    req = '0;
    tick(2);

    // wrap: serve core 3, then cores 3 and 1 pending -> 1 before 3
    req = 4'b1000;
    tick(4);
    chk("wr3_ack",  32'(ack_o[0]), 32'h8);
    req = 4'b1010;
    tick(2);                                           // cycle 6
    chk("wr1_gnt",  32'(gnt_o[0]), 32'h2);
    tick(3);                                           // cycle 9
    chk("wr1_ack",  32'(ack_o[0]), 32'h2);
    req = 4'b1000;
    tick(2);                                           // cycle 11
    chk("wr3b_gnt", 32'(gnt_o[0]), 32'h8);
    tick(3);                                           // cycle 14
    chk("wr3b_ack", 32'(ack_o[0]), 32'h8);
    req = '0;
    tick(2);

    // reset during WAIT of a core 1 read (ptr was 3 before it)
    req = 4'b0100; addr[2] = 8'h15;
    tick(1);
    req = '0;
    tick(3);
    chk("pre_ack2", 32'(ack_o[0]), 32'h4);
    tick(1);                                           // IDLE
    req = 4'b0010; addr[1] = 8'h03;
    tick(1);
    chk("ab_gnt",   32'(gnt_o[0]), 32'h2);
    chk("ab_men",   32'(men_o[0]), 32'h1);
    tick(1);                                           // WAIT
    RESET = 1'b0;
    req = 4'b1001; addr[0] = 8'h20; addr[3] = 8'h23;
    #1;
    chk("ab_men0",  32'(men_o[0]),   32'h0);
    chk("ab_busy0", 32'(busy_o[0]),  32'h0);
    chk("ab_gnt0",  32'(gnt_o[0]),   32'h0);
    chk("ab_rdata", 32'(rdata_o[0]), 32'h0);
    tick(1);
    chk("ab_noack", 32'(ack_o[0]),   32'h0);
    tick(1);
    chk("ab_noack2", 32'(ack_o[0]),  32'h0);
    RESET = 1'b1;                                      // cycle 0
    tick(1);
    chk("post_gnt",   32'(gnt_o[0]),   32'h1);
    chk("post_maddr", 32'(maddr_o[0]), 32'h20);
    chk("post_busy",  32'(busy_o[0]),  32'h1);
    tick(3);
    chk("post_ack",   32'(ack_o[0]),   32'h1);
    chk("post_rdata", 32'(rdata_o[0]), 32'h7A);
    req = '0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
